// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : ALU control codes, CCR flag bit indices and CCR width.
//               Build macro ALU_OVF_FLAG_EN widens the CCR to carry V.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_RLC  = 4'b0110;
    localparam logic [3:0] ALU_RRC  = 4'b0111;
    localparam logic [3:0] ALU_SETC = 4'b1000;
    localparam logic [3:0] ALU_CLRC = 4'b1001;
    localparam logic [3:0] ALU_NOT  = 4'b1010;
    localparam logic [3:0] ALU_NEG  = 4'b1011;
    localparam logic [3:0] ALU_INC  = 4'b1100;
    localparam logic [3:0] ALU_DEC  = 4'b1101;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

`ifdef ALU_OVF_FLAG_EN
    localparam int CCR_W = 4;
`else
    localparam int CCR_W = 3;
`endif

endpackage
`default_nettype wire

// File: rtl/alu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : alu_datapath
// Description : Combinational ALU core: result, carry/borrow out and signed
//               overflow for the 4-bit ALU control code.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_sub;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf_add;
    logic             w_ovf_sub;

    // All add/subtract style ops share one WIDTH+1 bit adder.
    always_comb begin
        w_x   = op_a;
        w_y   = op_b;
        w_sub = 1'b0;
        case (alu_ctrl)
            ALU_SUB: w_sub = 1'b1;
            ALU_NEG: begin w_x = '0;   w_sub = 1'b1; end
            ALU_INC: begin w_x = op_b; w_y = C_ONE; end
            ALU_DEC: begin w_x = op_b; w_y = C_ONE; w_sub = 1'b1; end
            default: ;
        endcase
    end

    assign w_ext     = w_sub ? ({1'b0, w_x} - {1'b0, w_y}) : ({1'b0, w_x} + {1'b0, w_y});
    assign w_sum     = w_ext[WIDTH-1:0];
    assign w_ovf_add = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    assign w_ovf_sub = (w_x[WIDTH-1] != w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);

    always_comb begin
        result    = '0;
        carry_out = carry_in;
        ovf       = 1'b0;
        case (alu_ctrl)
            ALU_NOP: result = op_b;
            ALU_ADD, ALU_INC: begin
                result    = w_sum;
                carry_out = w_ext[WIDTH];
                ovf       = w_ovf_add;
            end
            ALU_SUB, ALU_NEG, ALU_DEC: begin
                result    = w_sum;
                carry_out = w_ext[WIDTH];
                ovf       = w_ovf_sub;
            end
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_RLC: begin
                result    = {op_b[WIDTH-2:0], carry_in};
                carry_out = op_b[WIDTH-1];
            end
            ALU_RRC: begin
                result    = {carry_in, op_b[WIDTH-1:1]};
                carry_out = op_b[0];
            end
            ALU_SETC: begin result = op_b; carry_out = 1'b1; end
            ALU_CLRC: begin result = op_b; carry_out = 1'b0; end
            ALU_NOT:  result = ~op_b;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_ccr.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_ccr
// Description : Execute-stage ALU with registered CCR and interrupt shadow.
//               Define ALU_OVF_FLAG_EN to add the V flag at bit 3.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_ccr
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flag_we,
    input  logic [CCR_W-1:0] flag_clr,
    input  logic             ccr_save,
    input  logic             ccr_restore,
    output logic [WIDTH-1:0] result,
    output logic [CCR_W-1:0] flags,
    output logic [CCR_W-1:0] flags_nxt
);

    logic [CCR_W-1:0] ccr_q;
    logic [CCR_W-1:0] ccr_d;
    logic [CCR_W-1:0] shadow_q;
    logic [CCR_W-1:0] shadow_d;
    logic [CCR_W-1:0] w_op_flags;
    logic [CCR_W-1:0] w_flags_nxt;
    logic             w_carry_out;
    logic             w_ovf;
    logic             w_upd_zn;
    logic             w_upd_c;
    logic             w_upd_v;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (ccr_q[FLG_C]),
        .result    (result),
        .carry_out (w_carry_out),
        .ovf       (w_ovf)
    );

    always_comb begin
        w_upd_zn = 1'b0;
        w_upd_c  = 1'b0;
        w_upd_v  = 1'b0;
        case (alu_ctrl)
            ALU_ADD, ALU_SUB, ALU_NEG, ALU_INC, ALU_DEC: begin
                w_upd_zn = 1'b1;
                w_upd_c  = 1'b1;
                w_upd_v  = 1'b1;
            end
            ALU_RLC, ALU_RRC: begin
                w_upd_zn = 1'b1;
                w_upd_c  = 1'b1;
            end
            ALU_AND, ALU_OR, ALU_NOT: w_upd_zn = 1'b1;
            default: ;
        endcase
    end

`ifndef ALU_OVF_FLAG_EN
    logic w_unused_ovf;
    assign w_unused_ovf = w_ovf | w_upd_v;
`endif

    // Restore wins outright; flag_clr only trims a freshly computed value.
    always_comb begin
        w_op_flags = ccr_q;
        if (flag_we) begin
            if (w_upd_zn) begin
                w_op_flags[FLG_Z] = (result == '0);
                w_op_flags[FLG_N] = result[WIDTH-1];
            end
            if (w_upd_c) begin
                w_op_flags[FLG_C] = w_carry_out;
            end
`ifdef ALU_OVF_FLAG_EN
            if (w_upd_v) begin
                w_op_flags[FLG_V] = w_ovf;
            end
`endif
        end
        if ((alu_ctrl == ALU_SETC) || (alu_ctrl == ALU_CLRC)) begin
            w_op_flags[FLG_C] = w_carry_out;
        end
        w_flags_nxt = ccr_restore ? shadow_q : (w_op_flags & ~flag_clr);
        ccr_d       = en ? w_flags_nxt : ccr_q;
        shadow_d    = (en && ccr_save) ? ccr_q : shadow_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_q    <= '0;
            shadow_q <= '0;
        end else begin
            ccr_q    <= ccr_d;
            shadow_q <= shadow_d;
        end
    end

    assign flags     = ccr_q;
    assign flags_nxt = w_flags_nxt;

endmodule
`default_nettype wire

// File: doc/alu_exec_ccr.md
Name: alu_exec_ccr

Overview:
Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder and owns the condition-code register (CCR: Z, N, C, optionally V).
- Result path is combinational, so it is ready in the same cycle for the SE3 result mux.
- Flags are registered, with a shadow copy that is saved on interrupt entry and restored on RTI.
- Sits between the ID/EX pipeline register and the EX/MEM register; branch logic reads the flags.

Parameters:
- WIDTH, 8, datapath width in bits.
- CCR_W, 3, flag count; becomes 4 when the overflow feature is compiled in.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  stage enable; 0 = stall, so the CCR and the shadow copy hold.
- alu_ctrl  in  4  operation code from the control decoder.
- op_a  in  WIDTH  operand A, R[ra].
- op_b  in  WIDTH  operand B, R[rb] or constant 1 (already muxed by SE2).
- flag_we  in  1  allow this op to update flags. CU drives 0 for stack/LOOP/address adds.
- flag_clr  in  CCR_W  per-bit clear, e.g. clear Z after a taken JZ.
- ccr_save  in  1  interrupt entry: copy the CCR to the shadow register.
- ccr_restore  in  1  RTI: load the CCR from the shadow register.
- result  out  WIDTH  combinational ALU result.
- flags  out  CCR_W  registered CCR, {V,C,N,Z} with Z at bit 0.
- flags_nxt  out  CCR_W  combinational next-CCR value, for same-cycle branch forwarding.

Behaviour:
- Reset (rst=1 at a clk edge): CCR=0 and shadow=0. result and flags_nxt are combinational, so they follow the inputs. rst overrides every other input, including a save or restore in the same cycle.
- Operations, by alu_ctrl (result; flag updates). Flags not listed keep their value.
  - 0000 NOP: result=op_b; no flags.
  - 0010 ADD: op_a+op_b; Z N; C=carry out.
  - 0011 SUB: op_a-op_b; Z N; C=borrow (op_a<op_b, unsigned).
  - 0100 AND, 0101 OR: Z N; C kept.
  - 0110 RLC: {op_b[W-2:0],C}; C=op_b[W-1]; Z N.
  - 0111 RRC: {C,op_b[W-1:1]}; C=op_b[0]; Z N.
  - 1000 SETC: C=1. 1001 CLRC: C=0. Both: result=op_b; Z N kept.
  - 1010 NOT: ~op_b; Z N.
  - 1011 NEG: 0-op_b; Z N; C=(op_b!=0).
  - 1100 INC: op_b+1; Z N; C=carry out.
  - 1101 DEC: op_b-1; Z N; C=(op_b==0).
  - 0001, 1110, 1111: result=0; no flags.
- Flag definitions: Z=(result==0); N=result[W-1]. All arithmetic is computed at WIDTH+1 bits, and the carry is bit WIDTH.
- SETC and CLRC update C even when flag_we=0, because the instruction exists only to write C.
- flags_nxt is built in priority order:
  1. if ccr_restore: the shadow value;
  2. otherwise the op's updates (when flag_we=1, or for SETC/CLRC) applied over the CCR;
  3. then flag_clr bits forced to 0. flag_clr does not apply when restoring.
- CCR register: CCR<=flags_nxt on each clk edge with en=1. With en=0 it holds, and saves/restores are ignored.
- Shadow register: shadow<=CCR (the pre-update value) on ccr_save&en.
- ccr_save and ccr_restore in the same cycle: the restore loads the CCR from the old shadow, and the shadow captures the old CCR (a swap).
- Latency: result has 0 cycles; the flags output updates 1 cycle after the op.
- Wrap-around: results are taken modulo 2^WIDTH. Examples: INC 0xFF gives 0x00 with Z=1, C=1. DEC 0x00 gives 0xFF with N=1, C=1.

Optional Feature:
- Macro: ALU_OVF_FLAG_EN.
- Defined: CCR_W=4 and a V flag at bit 3. ADD and INC set V on signed overflow; SUB, NEG and DEC set V on signed subtraction overflow. Other ops keep V. V is saved and restored with the other flags.
- Undefined: CCR_W=3, no V logic. Ports narrow accordingly.

Decomposition:
- Package alu_pkg holds:
  - localparams for all ALU control codes (ALU_NOP … ALU_DEC);
  - flag bit indices FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3.
- One sub-module, alu_datapath: purely combinational, taking alu_ctrl, op_a, op_b and carry_in, and producing result, carry_out and ovf.
- The top level holds the flag-merge logic, the CCR and the shadow register.

Test Plan:
- Reset, then ADD 0xF0+0x20 with flag_we=1 → result=0x10. On the next cycle flags: C=1, Z=0, N=0.
- SUB 0x05-0x05, then RLC with op_b=0x80 and C=0:
  - SUB → Z=1, C=0;
  - RLC → result=0x00, C=1, Z=1.
- ADD with flag_we=0 (stack increment) → result correct, flags unchanged. In the same setup, SETC with flag_we=0 → C=1.
- Set Z via SUB, pulse ccr_save, CLRC plus an op that clears Z, then pulse ccr_restore → flags return to the saved value. Also pulse save and restore in the same cycle → the CCR and shadow swap.
- en=0 during an ADD and a ccr_save → flags and shadow unchanged. JZ taken with flag_clr=Z, simultaneous with an op setting Z → Z=0. rst asserted mid-sequence → flags=0 on the next cycle.
- With ALU_OVF_EN... corrected name ALU_OVF_FLAG_EN defined: ADD 0x7F+0x01 → result=0x80, V=1, N=1. NEG 0x80 → V=1, C=1.
